fm_rom_responder: RTL and testbench
===================================

Name: fm_rom_responder

Overview:
- Memory-side responder for the data-fetch stage of the search pipeline. It answers the fetch stage's enable/address requests on three tables:
  - C table: 4 entries × 32 b.
  - Occ table: 256 × 32 b, dual read port.
  - read_and_D table: 256 × {read 2 b, d 8 b}.
- Returns registered data after a fixed pipeline latency, with per-table valid strobes.
- Tables are filled at run time through a single load port, which stalls while reads are in flight.

Parameters:
- READ_LATENCY, 2: cycles from ce sample to data/valid; legal 1..4.
- OCC_DEPTH, 256: Occ entries; address width 8.
- RD_DEPTH, 256: read_and_D entries; address width 8.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- ce_rom_C  in  1  C-table read request.
- addr_rom_C  in  2  C-table address.
- ce_rom_Occ  in  1  Occ read request (both ports).
- addr1_rom_Occ  in  8  Occ port-1 address.
- addr2_rom_Occ  in  8  Occ port-2 address.
- ce_rom_read_and_D  in  1  read_and_D read request.
- addr_rom_read_and_D  in  8  read_and_D address.
- data  out  32  C-table result.
- data_1  out  32  Occ port-1 result.
- data_2  out  32  Occ port-2 result.
- d_i  out  8  D value.
- read_i  out  2  read symbol.
- vld_C  out  1  data valid, one cycle.
- vld_Occ  out  1  data_1/data_2 valid, one cycle.
- vld_rd  out  1  d_i/read_i valid, one cycle.
- load_valid  in  1  load request.
- load_ready  out  1  load accepted when high with load_valid.
- load_sel  in  2  target table: 0=C, 1=Occ, 2=read_and_D, 3=reserved (dropped).
- load_addr  in  8  target address; C uses bits [1:0].
- load_data  in  32  word; read_and_D uses [9:8]=read, [7:0]=d.
- busy  out  1  any read in flight.

Behaviour:
- Reset (async, rst=1):
  - All outputs 0, all pipeline valid bits 0, load_ready 0.
  - Table contents are not cleared.
  - Deassertion is synchronous to clk; load_ready rises the first cycle after reset release if no ce is high.
- Read path:
  - Each ce is sampled on a clk edge; the addressed word is read combinationally from the array and pushed into a READ_LATENCY-deep shift register alongside its ce bit.
  - At the pipeline tail the data outputs update and the matching vld_* pulses high for exactly one cycle.
  - Data outputs hold their last value when vld is low.
- Independence and throughput:
  - The three tables are independent; any combination of ce may be high in the same cycle.
  - Back-to-back requests are fully pipelined: one result per table per cycle.
- busy = OR of all ce inputs and all pipeline valid bits.
- Load handshake:
  - load_ready = !busy.
  - Transfer occurs on an edge where load_valid & load_ready.
  - Write takes effect for any read sampled on a later edge.
  - load_sel=3 completes the handshake but writes nothing.
- Ordering:
  - A ce rising in the same cycle as load_valid blocks the load (load_ready is low that cycle).
  - The load is retried while load_valid is held; the requester must hold load_valid and payload stable until accepted.
  - Reads therefore never observe a half-written word.
- Occ dual port: addr1 == addr2 is legal; both outputs carry the same word.
- Addresses are 8-bit and always in range; no wrap logic.
- Reset mid-operation: in-flight reads are discarded (no vld pulse). A pending load is not written.
- Arithmetic: none; pure storage and delay.

Optional Feature:
- Macro: FM_ROM_PARITY_EN.
- When defined:
  - Each stored word carries an even-parity bit computed at load.
  - On read, parity is rechecked at the pipeline tail.
  - Extra output port par_err (1 b, reset 0) pulses with the corresponding vld_* when any delivered word fails parity.
  - Data is delivered unchanged.
- When undefined: no parity storage, no par_err port.

Test Plan:
1. Load C[0..3]=0,10,25,40 via load port; ce_rom_C with addr 2 → after 2 cycles data=25, vld_C high for 1 cycle, busy low next cycle.
2. Load Occ[5]=0x11, Occ[9]=0x22; ce_rom_Occ addr1=5, addr2=9, then same cycle addr1=addr2=9 → data_1=0x11/data_2=0x22, then both 0x22, consecutive vld_Occ pulses.
3. Load read_and_D[7]=0x2A3 (read=2, d=0xA3); 4 back-to-back reads at 7 → four consecutive vld_rd cycles, d_i=0xA3, read_i=2 each.
4. Hold load_valid while ce_rom_Occ is asserted → load_ready low until READ_LATENCY cycles after the last ce; write then accepted once; subsequent read returns the new value.
5. Assert rst mid-stream with 2 reads in flight → outputs 0 immediately, no vld pulses after release; table contents preserved on re-read.
6. With FM_ROM_PARITY_EN, force a stored bit flip via backdoor on Occ[3]; read → par_err pulses with vld_Occ; an unflipped read gives par_err=0.

Source files
------------

// File: rtl/fm_rom_responder.sv
// fm_rom_responder: memory-side responder for the search-pipeline data fetch.
// It serves three tables (C 4x32, Occ 256x32 dual read, read_and_D 256x10).
// Each read request is sampled on a clk edge, and the word is read from the array at that edge.
// The word then passes through a READ_LATENCY-deep shift register. The last stage of that
// register drives the outputs directly.
// A single load port fills the tables at run time. It is only ready when no read is in flight.
// Optional build macro: FM_ROM_PARITY_EN adds an even-parity bit to each stored word
// and an extra par_err output that is checked at the pipeline tail.
// READ_LATENCY is legal in the range 1..4.
module fm_rom_responder #(
    parameter int READ_LATENCY = 2,
    parameter int OCC_DEPTH    = 256,
    parameter int RD_DEPTH     = 256
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ce_rom_C,
    input  logic [1:0]  addr_rom_C,
    input  logic        ce_rom_Occ,
    input  logic [7:0]  addr1_rom_Occ,
    input  logic [7:0]  addr2_rom_Occ,
    input  logic        ce_rom_read_and_D,
    input  logic [7:0]  addr_rom_read_and_D,
    output logic [31:0] data,
    output logic [31:0] data_1,
    output logic [31:0] data_2,
    output logic [7:0]  d_i,
    output logic [1:0]  read_i,
    output logic        vld_C,
    output logic        vld_Occ,
    output logic        vld_rd,
    input  logic        load_valid,
    output logic        load_ready,
    input  logic [1:0]  load_sel,
    input  logic [7:0]  load_addr,
    input  logic [31:0] load_data,
    output logic        busy
`ifdef FM_ROM_PARITY_EN
    ,
    output logic        par_err
`endif
);

`ifdef FM_ROM_PARITY_EN
    localparam int PW = 1;
`else
    localparam int PW = 0;
`endif
    // Stored word widths: payload plus the optional parity bit in the MSB
    localparam int CW = 32 + PW;
    localparam int OW = 32 + PW;
    localparam int RW = 10 + PW;
    localparam int LT = READ_LATENCY - 1;

    // Table storage; never reset so contents survive a reset pulse
    logic [CW-1:0] r_mem_c   [0:3];
    logic [OW-1:0] r_mem_occ [0:OCC_DEPTH-1];
    logic [RW-1:0] r_mem_rd  [0:RD_DEPTH-1];

    // Read pipelines: valid bit and data word per stage; Occ packs {port2, port1}
    logic [READ_LATENCY-1:0] r_c_vld;
    logic [READ_LATENCY-1:0] r_o_vld;
    logic [READ_LATENCY-1:0] r_r_vld;
    logic [CW-1:0]           r_c_dat [0:READ_LATENCY-1];
    logic [2*OW-1:0]         r_o_dat [0:READ_LATENCY-1];
    logic [RW-1:0]           r_r_dat [0:READ_LATENCY-1];

    logic          r_rdy_en;
    logic          w_busy_raw;
    logic          w_load_fire;
    logic [CW-1:0] w_wr_word;
    logic [RW-1:0] w_wr_rd;

    // Encode the load payload, adding parity when the feature is built in
`ifdef FM_ROM_PARITY_EN
    assign w_wr_word = {^load_data, load_data};
    assign w_wr_rd   = {^load_data[9:0], load_data[9:0]};
`else
    assign w_wr_word = load_data;
    assign w_wr_rd   = load_data[9:0];
`endif

    // Any request being sampled this cycle or still travelling down a pipeline
    assign w_busy_raw  = ce_rom_C | ce_rom_Occ | ce_rom_read_and_D
                       | (|r_c_vld) | (|r_o_vld) | (|r_r_vld);
    assign busy        = w_busy_raw & ~rst;
    // Loads wait for an idle read path, so a read can never see a partly written word
    assign load_ready  = r_rdy_en & ~w_busy_raw;
    assign w_load_fire = load_valid & load_ready;

    // Hold load_ready off during reset and until the first edge after release
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rdy_en <= 1'b0;
        end else begin
            r_rdy_en <= 1'b1;
        end
    end

    // Table writes from the load port; selector 3 is accepted but writes nothing
    always_ff @(posedge clk) begin
        if (w_load_fire) begin
            case (load_sel)
                2'd0:    r_mem_c[load_addr[1:0]] <= w_wr_word;
                2'd1:    r_mem_occ[load_addr]    <= w_wr_word;
                2'd2:    r_mem_rd[load_addr]     <= w_wr_rd;
                default: ;
            endcase
        end
    end

    // C pipeline: stage data only advances with a valid word so the tail holds its value
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_c_vld <= '0;
            for (int k = 0; k < READ_LATENCY; k++) begin
                r_c_dat[k] <= '0;
            end
        end else begin
            r_c_vld[0] <= ce_rom_C;
            if (ce_rom_C) begin
                r_c_dat[0] <= r_mem_c[addr_rom_C];
            end
            for (int k = 1; k < READ_LATENCY; k++) begin
                r_c_vld[k] <= r_c_vld[k-1];
                if (r_c_vld[k-1]) begin
                    r_c_dat[k] <= r_c_dat[k-1];
                end
            end
        end
    end

    // Occ pipeline: both ports read together under one ce
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_o_vld <= '0;
            for (int k = 0; k < READ_LATENCY; k++) begin
                r_o_dat[k] <= '0;
            end
        end else begin
            r_o_vld[0] <= ce_rom_Occ;
            if (ce_rom_Occ) begin
                r_o_dat[0] <= {r_mem_occ[addr2_rom_Occ], r_mem_occ[addr1_rom_Occ]};
            end
            for (int k = 1; k < READ_LATENCY; k++) begin
                r_o_vld[k] <= r_o_vld[k-1];
                if (r_o_vld[k-1]) begin
                    r_o_dat[k] <= r_o_dat[k-1];
                end
            end
        end
    end

    // read_and_D pipeline
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_r_vld <= '0;
            for (int k = 0; k < READ_LATENCY; k++) begin
                r_r_dat[k] <= '0;
            end
        end else begin
            r_r_vld[0] <= ce_rom_read_and_D;
            if (ce_rom_read_and_D) begin
                r_r_dat[0] <= r_mem_rd[addr_rom_read_and_D];
            end
            for (int k = 1; k < READ_LATENCY; k++) begin
                r_r_vld[k] <= r_r_vld[k-1];
                if (r_r_vld[k-1]) begin
                    r_r_dat[k] <= r_r_dat[k-1];
                end
            end
        end
    end

    // Outputs come straight from the last pipeline stage
    assign vld_C   = r_c_vld[LT];
    assign vld_Occ = r_o_vld[LT];
    assign vld_rd  = r_r_vld[LT];
    assign data    = r_c_dat[LT][31:0];
    assign data_1  = r_o_dat[LT][31:0];
    assign data_2  = r_o_dat[LT][OW+31:OW];
    assign d_i     = r_r_dat[LT][7:0];
    assign read_i  = r_r_dat[LT][9:8];

`ifdef FM_ROM_PARITY_EN
    // A stored word plus its parity bit must XOR to zero; flag any delivered word that does not
    assign par_err = (vld_C   & (^r_c_dat[LT]))
                   | (vld_Occ & ((^r_o_dat[LT][OW-1:0]) | (^r_o_dat[LT][2*OW-1:OW])))
                   | (vld_rd  & (^r_r_dat[LT]));
`endif

endmodule

// File: tb/tb_fm_rom_responder.sv
// Bench for fm_rom_responder: table of load/read vectors plus hand-written
// sequences for back-to-back reads, load stalling, reset mid-stream and parity.
module tb_fm_rom_responder;
    localparam int LAT = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        ce_rom_C = 1'b0;
    logic [1:0]  addr_rom_C = '0;
    logic        ce_rom_Occ = 1'b0;
    logic [7:0]  addr1_rom_Occ = '0;
    logic [7:0]  addr2_rom_Occ = '0;
    logic        ce_rom_read_and_D = 1'b0;
    logic [7:0]  addr_rom_read_and_D = '0;
    logic [31:0] data, data_1, data_2;
    logic [7:0]  d_i;
    logic [1:0]  read_i;
    logic        vld_C, vld_Occ, vld_rd;
    logic        load_valid = 1'b0;
    logic        load_ready;
    logic [1:0]  load_sel = '0;
    logic [7:0]  load_addr = '0;
    logic [31:0] load_data = '0;
    logic        busy;
`ifdef FM_ROM_PARITY_EN
    logic        par_err;
`endif

    int n_total = 0;
    int n_bad   = 0;

    fm_rom_responder #(.READ_LATENCY(LAT), .OCC_DEPTH(256), .RD_DEPTH(256)) dut (
        .clk(clk), .rst(rst),
        .ce_rom_C(ce_rom_C), .addr_rom_C(addr_rom_C),
        .ce_rom_Occ(ce_rom_Occ), .addr1_rom_Occ(addr1_rom_Occ), .addr2_rom_Occ(addr2_rom_Occ),
        .ce_rom_read_and_D(ce_rom_read_and_D), .addr_rom_read_and_D(addr_rom_read_and_D),
        .data(data), .data_1(data_1), .data_2(data_2), .d_i(d_i), .read_i(read_i),
        .vld_C(vld_C), .vld_Occ(vld_Occ), .vld_rd(vld_rd),
        .load_valid(load_valid), .load_ready(load_ready), .load_sel(load_sel),
        .load_addr(load_addr), .load_data(load_data), .busy(busy)
`ifdef FM_ROM_PARITY_EN
        , .par_err(par_err)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          is_load;
        logic [1:0]  sel;      // table: 0=C 1=Occ 2=read_and_D 3=reserved
        logic [7:0]  a1;
        logic [7:0]  a2;
        logic [31:0] wd;
        logic [31:0] e1;       // data / data_1 / d_i
        logic [31:0] e2;       // data_2 / read_i
    } vec_t;

    vec_t vecs [0:19];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic vld_of(input int tbl);
        case (tbl)
            0:       return vld_C;
            1:       return vld_Occ;
            default: return vld_rd;
        endcase
    endfunction

    task automatic do_load(input logic [1:0] sel, input logic [7:0] a, input logic [31:0] d);
        bit done;
        done = 0;
        load_valid = 1'b1; load_sel = sel; load_addr = a; load_data = d;
        #1;
        for (int i = 0; i < 20 && !done; i++) begin
            if (load_ready) done = 1;
            tick();
        end
        load_valid = 1'b0;
        chk("load_accept", {31'd0, done}, 32'd1);
    endtask

    task automatic do_read(input int tbl, input logic [7:0] a1, input logic [7:0] a2,
                           input logic [31:0] e1, input logic [31:0] e2);
        case (tbl)
            0:       begin ce_rom_C = 1'b1; addr_rom_C = a1[1:0]; end
            1:       begin ce_rom_Occ = 1'b1; addr1_rom_Occ = a1; addr2_rom_Occ = a2; end
            default: begin ce_rom_read_and_D = 1'b1; addr_rom_read_and_D = a1; end
        endcase
        tick();
        ce_rom_C = 1'b0; ce_rom_Occ = 1'b0; ce_rom_read_and_D = 1'b0;
        for (int k = 0; k < LAT - 1; k++) begin
            chk("vld_early", {31'd0, vld_of(tbl)}, 32'd0);
            tick();
        end
        chk("vld_pulse", {31'd0, vld_of(tbl)}, 32'd1);
        case (tbl)
            0: chk("c_data", data, e1);
            1: begin chk("occ_data_1", data_1, e1); chk("occ_data_2", data_2, e2); end
            default: begin chk("rd_d_i", {24'd0, d_i}, e1); chk("rd_read_i", {30'd0, read_i}, e2); end
        endcase
`ifdef FM_ROM_PARITY_EN
        chk("par_err_clean", {31'd0, par_err}, 32'd0);
`endif
        tick();
        chk("vld_drop", {31'd0, vld_of(tbl)}, 32'd0);
        chk("busy_idle", {31'd0, busy}, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1);
    end

    initial begin
        int seen;
        //            load sel   a1     a2     wd             e1             e2
        vecs[0]  = '{1'b1, 2'd0, 8'd0,  8'd0,  32'd0,         32'd0,         32'd0};
        vecs[1]  = '{1'b1, 2'd0, 8'd1,  8'd0,  32'd10,        32'd0,         32'd0};
        vecs[2]  = '{1'b1, 2'd0, 8'd2,  8'd0,  32'd25,        32'd0,         32'd0};
        vecs[3]  = '{1'b1, 2'd0, 8'd3,  8'd0,  32'd40,        32'd0,         32'd0};
        vecs[4]  = '{1'b1, 2'd1, 8'd5,  8'd0,  32'h11,        32'd0,         32'd0};
        vecs[5]  = '{1'b1, 2'd1, 8'd9,  8'd0,  32'h22,        32'd0,         32'd0};
        vecs[6]  = '{1'b1, 2'd2, 8'd7,  8'd0,  32'h2A3,       32'd0,         32'd0};
        vecs[7]  = '{1'b1, 2'd1, 8'd3,  8'd0,  32'hDEADBEEF,  32'd0,         32'd0};
        vecs[8]  = '{1'b1, 2'd2, 8'd0,  8'd0,  32'h155,       32'd0,         32'd0};
        vecs[9]  = '{1'b0, 2'd0, 8'd2,  8'd0,  32'd0,         32'd25,        32'd0};
        vecs[10] = '{1'b0, 2'd0, 8'd0,  8'd0,  32'd0,         32'd0,         32'd0};
        vecs[11] = '{1'b0, 2'd0, 8'd3,  8'd0,  32'd0,         32'd40,        32'd0};
        vecs[12] = '{1'b0, 2'd1, 8'd5,  8'd9,  32'd0,         32'h11,        32'h22};
        vecs[13] = '{1'b0, 2'd2, 8'd7,  8'd0,  32'd0,         32'hA3,        32'd2};
        vecs[14] = '{1'b0, 2'd2, 8'd0,  8'd0,  32'd0,         32'h55,        32'd1};
        vecs[15] = '{1'b1, 2'd3, 8'd5,  8'd0,  32'h99,        32'd0,         32'd0};
        vecs[16] = '{1'b0, 2'd1, 8'd5,  8'd3,  32'd0,         32'h11,        32'hDEADBEEF};
        vecs[17] = '{1'b1, 2'd0, 8'hFD, 8'd0,  32'd77,        32'd0,         32'd0};
        vecs[18] = '{1'b0, 2'd0, 8'd1,  8'd0,  32'd0,         32'd77,        32'd0};
        vecs[19] = '{1'b0, 2'd1, 8'd9,  8'd9,  32'd0,         32'h22,        32'h22};

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_data", data, 32'd0);
        chk("rst_vld", {29'd0, vld_C, vld_Occ, vld_rd}, 32'd0);
        chk("rst_load_ready", {31'd0, load_ready}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        rst = 1'b0;
        tick();
        chk("ready_after_rst", {31'd0, load_ready}, 32'd1);

        // Table-driven loads and single reads
        for (int i = 0; i < 20; i++) begin
            $display("vec %0d: %s sel=%0d a1=%h a2=%h wd=%h", i,
                     vecs[i].is_load ? "load" : "read", vecs[i].sel, vecs[i].a1, vecs[i].a2, vecs[i].wd);
            if (vecs[i].is_load) do_load(vecs[i].sel, vecs[i].a1, vecs[i].wd);
            else do_read(int'(vecs[i].sel), vecs[i].a1, vecs[i].a2, vecs[i].e1, vecs[i].e2);
        end

        // Back-to-back Occ reads, second with equal port addresses
        $display("seq: occ back-to-back");
        ce_rom_Occ = 1'b1; addr1_rom_Occ = 8'd5; addr2_rom_Occ = 8'd9;
        tick();
        addr1_rom_Occ = 8'd9; addr2_rom_Occ = 8'd9;
        tick();
        ce_rom_Occ = 1'b0;
        chk("b2b_occ_vld0", {31'd0, vld_Occ}, 32'd1);
        chk("b2b_occ_d1_0", data_1, 32'h11);
        chk("b2b_occ_d2_0", data_2, 32'h22);
        tick();
        chk("b2b_occ_vld1", {31'd0, vld_Occ}, 32'd1);
        chk("b2b_occ_d1_1", data_1, 32'h22);
        chk("b2b_occ_d2_1", data_2, 32'h22);
        tick();
        chk("b2b_occ_end", {31'd0, vld_Occ}, 32'd0);

        // Four back-to-back read_and_D reads
        $display("seq: rd four back-to-back");
        ce_rom_read_and_D = 1'b1; addr_rom_read_and_D = 8'd7;
        tick();
        for (int i = 0; i < 4; i++) begin
            if (i == 3) ce_rom_read_and_D = 1'b0;
            tick();
            chk("b2b_rd_vld", {31'd0, vld_rd}, 32'd1);
            chk("b2b_rd_d", {24'd0, d_i}, 32'hA3);
            chk("b2b_rd_read", {30'd0, read_i}, 32'd2);
        end
        tick();
        chk("b2b_rd_end", {31'd0, vld_rd}, 32'd0);
        chk("b2b_rd_busy", {31'd0, busy}, 32'd0);

        // Load held off while Occ reads are in flight
        $display("seq: load stalled by reads");
        ce_rom_Occ = 1'b1; addr1_rom_Occ = 8'd3; addr2_rom_Occ = 8'd3;
        load_valid = 1'b1; load_sel = 2'd1; load_addr = 8'd3; load_data = 32'h12345678;
        #1;
        chk("stall_same_cycle", {31'd0, load_ready}, 32'd0);
        tick();
        tick();
        chk("stall_old_word", data_1, 32'hDEADBEEF);
        tick();
        ce_rom_Occ = 1'b0;
        #1;
        chk("stall_tail0", {31'd0, load_ready}, 32'd0);
        tick();
        chk("stall_tail1", {31'd0, load_ready}, 32'd0);
        chk("stall_last_old", data_1, 32'hDEADBEEF);
        tick();
        chk("stall_release", {31'd0, load_ready}, 32'd1);
        tick();
        load_valid = 1'b0;
        do_read(1, 8'd3, 8'd3, 32'h12345678, 32'h12345678);

        // Reset with reads in flight
        $display("seq: reset mid-stream");
        ce_rom_C = 1'b1; addr_rom_C = 2'd2;
        ce_rom_read_and_D = 1'b1; addr_rom_read_and_D = 8'd0;
        tick();
        ce_rom_C = 1'b0; ce_rom_read_and_D = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        chk("mid_rst_data", data, 32'd0);
        chk("mid_rst_data_1", data_1, 32'd0);
        chk("mid_rst_d_i", {24'd0, d_i}, 32'd0);
        chk("mid_rst_vld", {29'd0, vld_C, vld_Occ, vld_rd}, 32'd0);
        chk("mid_rst_busy_ready", {30'd0, busy, load_ready}, 32'd0);
        tick();
        tick();
        #2;
        rst = 1'b0;
        seen = 0;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (vld_C | vld_Occ | vld_rd) seen++;
        end
        chk("no_vld_after_rst", seen, 32'd0);
        do_read(0, 8'd2, 8'd0, 32'd25, 32'd0);
        do_read(2, 8'd7, 8'd0, 32'hA3, 32'd2);

`ifdef FM_ROM_PARITY_EN
        // Corrupt one stored bit behind the load port and expect a parity flag
        $display("seq: parity backdoor flip");
        dut.r_mem_occ[3][0] = ~dut.r_mem_occ[3][0];
        ce_rom_Occ = 1'b1; addr1_rom_Occ = 8'd3; addr2_rom_Occ = 8'd5;
        tick();
        ce_rom_Occ = 1'b0;
        repeat (LAT - 1) tick();
        chk("par_vld", {31'd0, vld_Occ}, 32'd1);
        chk("par_err_set", {31'd0, par_err}, 32'd1);
        chk("par_data_unchanged", data_1, 32'h12345679);
        tick();
        chk("par_err_drop", {31'd0, par_err}, 32'd0);
        do_read(1, 8'd5, 8'd9, 32'h11, 32'h22);
`endif

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end
endmodule
